hdmi_pixel_proc: RTL
====================

Name: hdmi_pixel_proc

Overview:
- Parametrised, mode-selectable pixel processor on the HDMI video path, sitting between the video source and the HDMI TX.
- Supports four modes: pass-through, weighted grayscale, threshold binarisation and colour inversion.
- Configuration is shadowed and applied only at frame boundaries, so a frame is never split between two modes.
- Sync and DE are delayed to match a fixed 3-cycle data pipeline.

Parameters:
- DW, 8: bits per colour channel.
- COEF_R, 306: red luma weight.
- COEF_G, 601: green luma weight.
- COEF_B, 117: blue luma weight.
- COEF_SHIFT, 10: right shift after the weighted sum.
- VS_POL, 1: active level of vs_in (1 = active-high).
- CNT_W, 24: width of the pixel counter (stats feature).
- SUM_W, 32: width of the luma accumulator (stats feature).

Ports:
- pixclk_in  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_mode  in  2  0 = pass-through, 1 = gray, 2 = binary, 3 = invert.
- cfg_thresh  in  DW  binarisation threshold.
- vs_in  in  1  vertical sync.
- hs_in  in  1  horizontal sync.
- de_in  in  1  data enable.
- r_in, g_in, b_in  in  DW each  input pixel.
- pixclk_out  out  1  equal to pixclk_in (direct assign).
- vs_out, hs_out, de_out  out  1 each  syncs delayed 3 cycles.
- r_out, g_out, b_out  out  DW each  processed pixel.
- frame_pix_cnt  out  CNT_W  DE pixels counted in the last complete frame.
- frame_luma_sum  out  SUM_W  gray sum over the last complete frame.
- stats_valid  out  1  1-cycle pulse when the stats outputs update.

Behaviour:
- Reset: rst_n low asynchronously clears every register. All outputs are 0, active mode is 0, active threshold is 0, FSM is in WAIT_FRAME.
- Pipeline, latency exactly 3 cycles, input to output, for data and syncs:
  - S1: register the three products, each DW+11 bits wide.
  - S2: sum, shift right by COEF_SHIFT, saturate to 2^DW-1 → gray; pass the S1 pixel copy through.
  - S3: mode mux and output registers.
- Frame-start event (fs): rising edge of the active level of the S2-stage vs (vs_d2 XOR !VS_POL). fs is aligned with the gray data.
- Shadow config: on fs, cfg_mode and cfg_thresh are captured into the active registers. The value present on the fs cycle is the one used. Config changes mid-frame have no effect until the next fs.
- FSM:
  - WAIT_FRAME → RUN on the first fs after reset.
  - RUN → RUN indefinitely; only reset leaves RUN.
  - In WAIT_FRAME, de_out is forced to 0 and r/g/b_out to 0. vs_out and hs_out still follow the delayed inputs.
  - Reset mid-frame returns to WAIT_FRAME; the partial frame is discarded.
- S3 mode mux (applied when the S2 DE is high; outputs are 0 when DE is low):
  - Mode 0: output equals the delayed input channels.
  - Mode 1: r = g = b = gray.
  - Mode 2: all channels are 2^DW-1 if gray >= thresh, else 0. Boundary: gray == thresh gives all-ones; thresh 0 gives all-ones everywhere.
  - Mode 3: each channel is the bitwise inverse of its delayed input channel.
- Weights summing above 2^COEF_SHIFT can overflow; gray saturates to 2^DW-1.

Optional Feature:
- Macro: HDMI_PROC_STATS_EN.
- When defined:
  - Pixel counter and luma accumulator advance on the S2 DE in RUN.
  - Both saturate at all-ones; they do not wrap.
  - On fs in RUN, they are copied to frame_pix_cnt and frame_luma_sum, stats_valid pulses for 1 cycle, and both are cleared. If DE is high on the same cycle as fs, that pixel counts toward the new frame.
  - The first fs after reset (WAIT_FRAME → RUN) clears the accumulators without a pulse.
- When undefined: no stats logic; frame_pix_cnt, frame_luma_sum and stats_valid are tied to 0.

Decomposition:
- Package hdmi_proc_pkg holds:
  - mode encodings MODE_PASS, MODE_GRAY, MODE_BIN, MODE_INV;
  - FSM state encodings ST_WAIT_FRAME, ST_RUN;
  - pipeline depth constant PIPE_LAT = 3.
- One sub-module, rgb2gray_pipe: the S1–S2 weighted-sum pipeline with saturation, carrying DE/syncs/pixel alongside. The top level contains the FSM, shadow config, mode mux and stats.

Test Plan:
- Reset, then pixel (255,255,255), mode 1, after one fs → r/g/b_out = 255 exactly 3 cycles after de_in; de_out rises 3 cycles after de_in.
- Mode 1, pixel (100,50,200) → gray = (30600 + 30050 + 23400) >> 10 = 82 on all channels.
- Mode 2, thresh 82: pixel (100,50,200) → 255,255,255; thresh 83 → 0,0,0.
- Mode changed from 0 to 3 mid-frame → output stays pass-through until the next fs; afterwards (10,20,30) → (245,235,225).
- Pixels before the first fs after reset → de_out stays 0 and RGB is 0, while vs_out/hs_out toggle with 3-cycle delay.
- STATS_EN: frame of 4 DE pixels of gray 82 → at next fs, stats_valid is a 1-cycle pulse, frame_pix_cnt = 4, frame_luma_sum = 328. No pulse on the first fs after reset.

Source files
------------

// File: rtl/hdmi_proc_pkg.sv
// Shared types and constants for the HDMI pixel processor.
package hdmi_proc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_BIN  = 2'd2,
    MODE_INV  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_WAIT_FRAME = 1'b0,
    ST_RUN        = 1'b1
  } state_e;

  localparam int unsigned PIPE_LAT = 3;

  // Normalise a sync to "1 = active" given its polarity.
  function automatic logic sync_active(input logic sync, input bit pol);
    return sync ^ !pol;
  endfunction

endpackage

// File: rtl/rgb2gray_pipe.sv
// Two-stage weighted-sum luma pipeline with saturation; carries pixel, DE and syncs
// alongside so every output is aligned with o_gray.
module rgb2gray_pipe #(
  parameter int unsigned DW         = 8,
  parameter int unsigned COEF_R     = 306,
  parameter int unsigned COEF_G     = 601,
  parameter int unsigned COEF_B     = 117,
  parameter int unsigned COEF_SHIFT = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_vs,
  input  logic          i_hs,
  input  logic          i_de,
  input  logic [DW-1:0] i_r,
  input  logic [DW-1:0] i_g,
  input  logic [DW-1:0] i_b,
  output logic          o_vs,
  output logic          o_hs,
  output logic          o_de,
  output logic [DW-1:0] o_r,
  output logic [DW-1:0] o_g,
  output logic [DW-1:0] o_b,
  output logic [DW-1:0] o_gray
);

  localparam int unsigned PW = DW + 11;
  localparam int unsigned SW = PW + 2;
  localparam logic [SW-1:0] GRAY_MAX = {{(SW - DW){1'b0}}, {DW{1'b1}}};

  logic [PW-1:0] r_prod_r, r_prod_g, r_prod_b;
  logic          r_vs_d1, r_hs_d1, r_de_d1;
  logic [DW-1:0] r_r_d1, r_g_d1, r_b_d1;

  logic          r_vs_d2, r_hs_d2, r_de_d2;
  logic [DW-1:0] r_r_d2, r_g_d2, r_b_d2, r_gray_d2;

  logic [PW-1:0] w_prod_r, w_prod_g, w_prod_b;
  logic [SW-1:0] w_sum, w_shift;
  logic [DW-1:0] w_gray;

  assign w_prod_r = PW'(i_r) * PW'(COEF_R);
  assign w_prod_g = PW'(i_g) * PW'(COEF_G);
  assign w_prod_b = PW'(i_b) * PW'(COEF_B);

  assign w_sum   = SW'(r_prod_r) + SW'(r_prod_g) + SW'(r_prod_b);
  assign w_shift = w_sum >> COEF_SHIFT;
  // Weights summing above 2^COEF_SHIFT can push the result past full scale.
  assign w_gray  = (w_shift > GRAY_MAX) ? {DW{1'b1}} : w_shift[DW-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prod_r  <= '0;
      r_prod_g  <= '0;
      r_prod_b  <= '0;
      r_vs_d1   <= 1'b0;
      r_hs_d1   <= 1'b0;
      r_de_d1   <= 1'b0;
      r_r_d1    <= '0;
      r_g_d1    <= '0;
      r_b_d1    <= '0;
      r_vs_d2   <= 1'b0;
      r_hs_d2   <= 1'b0;
      r_de_d2   <= 1'b0;
      r_r_d2    <= '0;
      r_g_d2    <= '0;
      r_b_d2    <= '0;
      r_gray_d2 <= '0;
    end else begin
      r_prod_r  <= w_prod_r;
      r_prod_g  <= w_prod_g;
      r_prod_b  <= w_prod_b;
      r_vs_d1   <= i_vs;
      r_hs_d1   <= i_hs;
      r_de_d1   <= i_de;
      r_r_d1    <= i_r;
      r_g_d1    <= i_g;
      r_b_d1    <= i_b;
      r_vs_d2   <= r_vs_d1;
      r_hs_d2   <= r_hs_d1;
      r_de_d2   <= r_de_d1;
      r_r_d2    <= r_r_d1;
      r_g_d2    <= r_g_d1;
      r_b_d2    <= r_b_d1;
      r_gray_d2 <= w_gray;
    end
  end

  assign o_vs   = r_vs_d2;
  assign o_hs   = r_hs_d2;
  assign o_de   = r_de_d2;
  assign o_r    = r_r_d2;
  assign o_g    = r_g_d2;
  assign o_b    = r_b_d2;
  assign o_gray = r_gray_d2;

endmodule

// File: rtl/hdmi_pixel_proc.sv
// Mode-selectable HDMI pixel processor: frame-synchronous config, 3-cycle pipeline.
// Define HDMI_PROC_STATS_EN to build the per-frame pixel count / luma sum statistics.
module hdmi_pixel_proc
  import hdmi_proc_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned COEF_R     = 306,
  parameter int unsigned COEF_G     = 601,
  parameter int unsigned COEF_B     = 117,
  parameter int unsigned COEF_SHIFT = 10,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned SUM_W      = 32
) (
  input  logic             pixclk_in,
  input  logic             rst_n,
  input  logic [1:0]       cfg_mode,
  input  logic [DW-1:0]    cfg_thresh,
  input  logic             vs_in,
  input  logic             hs_in,
  input  logic             de_in,
  input  logic [DW-1:0]    r_in,
  input  logic [DW-1:0]    g_in,
  input  logic [DW-1:0]    b_in,
  output logic             pixclk_out,
  output logic             vs_out,
  output logic             hs_out,
  output logic             de_out,
  output logic [DW-1:0]    r_out,
  output logic [DW-1:0]    g_out,
  output logic [DW-1:0]    b_out,
  output logic [CNT_W-1:0] frame_pix_cnt,
  output logic [SUM_W-1:0] frame_luma_sum,
  output logic             stats_valid
);

  logic          w_vs_d2, w_hs_d2, w_de_d2;
  logic [DW-1:0] w_r_d2, w_g_d2, w_b_d2, w_gray;

  rgb2gray_pipe #(
    .DW         (DW),
    .COEF_R     (COEF_R),
    .COEF_G     (COEF_G),
    .COEF_B     (COEF_B),
    .COEF_SHIFT (COEF_SHIFT)
  ) u_rgb2gray_pipe (
    .i_clk   (pixclk_in),
    .i_rst_n (rst_n),
    .i_vs    (vs_in),
    .i_hs    (hs_in),
    .i_de    (de_in),
    .i_r     (r_in),
    .i_g     (g_in),
    .i_b     (b_in),
    .o_vs    (w_vs_d2),
    .o_hs    (w_hs_d2),
    .o_de    (w_de_d2),
    .o_r     (w_r_d2),
    .o_g     (w_g_d2),
    .o_b     (w_b_d2),
    .o_gray  (w_gray)
  );

  state_e        r_state;
  mode_e         r_mode;
  logic [DW-1:0] r_thresh;
  logic          r_vs_out, r_hs_out, r_de_out;
  logic [DW-1:0] r_red, r_grn, r_blu;

  logic          w_fs, w_run;
  mode_e         w_mode;
  logic [DW-1:0] w_thresh, w_bin;
  logic [DW-1:0] w_red, w_grn, w_blu;

  // r_vs_out is the S2 vs one cycle later, so it doubles as the edge-detect history.
  assign w_fs = sync_active(w_vs_d2, VS_POL) & ~sync_active(r_vs_out, VS_POL);

  // The fs cycle already belongs to the new frame, so it sees the new config and state.
  assign w_mode   = w_fs ? mode_e'(cfg_mode) : r_mode;
  assign w_thresh = w_fs ? cfg_thresh : r_thresh;
  assign w_run    = (r_state == ST_RUN) | w_fs;
  assign w_bin    = (w_gray >= w_thresh) ? {DW{1'b1}} : '0;

  always_comb begin
    w_red = '0;
    w_grn = '0;
    w_blu = '0;
    if (w_run && w_de_d2) begin
      unique case (w_mode)
        MODE_PASS: begin
          w_red = w_r_d2;
          w_grn = w_g_d2;
          w_blu = w_b_d2;
        end
        MODE_GRAY: begin
          w_red = w_gray;
          w_grn = w_gray;
          w_blu = w_gray;
        end
        MODE_BIN: begin
          w_red = w_bin;
          w_grn = w_bin;
          w_blu = w_bin;
        end
        MODE_INV: begin
          w_red = ~w_r_d2;
          w_grn = ~w_g_d2;
          w_blu = ~w_b_d2;
        end
      endcase
    end
  end

  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_WAIT_FRAME;
      r_mode   <= MODE_PASS;
      r_thresh <= '0;
      r_vs_out <= 1'b0;
      r_hs_out <= 1'b0;
      r_de_out <= 1'b0;
      r_red    <= '0;
      r_grn    <= '0;
      r_blu    <= '0;
    end else begin
      r_vs_out <= w_vs_d2;
      r_hs_out <= w_hs_d2;
      r_de_out <= w_run & w_de_d2;
      r_red    <= w_red;
      r_grn    <= w_grn;
      r_blu    <= w_blu;
      if (w_fs) begin
        r_mode   <= mode_e'(cfg_mode);
        r_thresh <= cfg_thresh;
      end
      unique case (r_state)
        ST_WAIT_FRAME: if (w_fs) r_state <= ST_RUN;
        ST_RUN:        r_state <= ST_RUN;
      endcase
    end
  end

  assign pixclk_out = pixclk_in;
  assign vs_out     = r_vs_out;
  assign hs_out     = r_hs_out;
  assign de_out     = r_de_out;
  assign r_out      = r_red;
  assign g_out      = r_grn;
  assign b_out      = r_blu;

`ifdef HDMI_PROC_STATS_EN
  logic [CNT_W-1:0] r_pix_cnt, r_frame_cnt;
  logic [SUM_W-1:0] r_luma_sum, r_frame_sum;
  logic             r_stats_valid;

  logic [SUM_W:0]   w_sum_add;
  logic [SUM_W-1:0] w_sum_sat, w_gray_ext;
  logic [CNT_W-1:0] w_cnt_sat;

  assign w_gray_ext = SUM_W'(w_gray);
  assign w_sum_add  = {1'b0, r_luma_sum} + {1'b0, w_gray_ext};
  assign w_sum_sat  = w_sum_add[SUM_W] ? {SUM_W{1'b1}} : w_sum_add[SUM_W-1:0];
  assign w_cnt_sat  = (&r_pix_cnt) ? r_pix_cnt : r_pix_cnt + CNT_W'(1);

  always_ff @(posedge pixclk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt     <= '0;
      r_luma_sum    <= '0;
      r_frame_cnt   <= '0;
      r_frame_sum   <= '0;
      r_stats_valid <= 1'b0;
    end else begin
      r_stats_valid <= 1'b0;
      if (w_fs) begin
        // The very first fs only starts counting; there is no finished frame to report.
        if (r_state == ST_RUN) begin
          r_frame_cnt   <= r_pix_cnt;
          r_frame_sum   <= r_luma_sum;
          r_stats_valid <= 1'b1;
        end
        r_pix_cnt  <= w_de_d2 ? CNT_W'(1) : '0;
        r_luma_sum <= w_de_d2 ? w_gray_ext : '0;
      end else if ((r_state == ST_RUN) && w_de_d2) begin
        r_pix_cnt  <= w_cnt_sat;
        r_luma_sum <= w_sum_sat;
      end
    end
  end

  assign frame_pix_cnt  = r_frame_cnt;
  assign frame_luma_sum = r_frame_sum;
  assign stats_valid    = r_stats_valid;
`else
  assign frame_pix_cnt  = '0;
  assign frame_luma_sum = '0;
  assign stats_valid    = 1'b0;
`endif

endmodule
